st_frame_writer: RTL and testbench



---
 rtl/video_pkg.sv | 31 +++
 rtl/st_frame_writer.sv | 117 +++++++++++
 tb/tb_st_frame_writer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video types: frame geometry, RGB pixel formats and the frame-writer state encoding.
package video_pkg;

    localparam int FRAME_W      = 320;
    localparam int FRAME_H      = 240;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } rgb30_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_t;

    // Keep only the top nibble of each channel; plain truncation, no rounding.
    function automatic rgb12_t pack_rgb12(input rgb30_t px);
        rgb12_t q;
        q.r = px.r[9:6];
        q.g = px.g[9:6];
        q.b = px.b[9:6];
        return q;
    endfunction

endpackage

// File: rtl/st_frame_writer.sv
// Avalon-ST video sink that writes framed RGB beats linearly into the 12-bit frame buffer,
// checking sop/eop framing, honouring freeze between frames and counting good frames.
module st_frame_writer
    import video_pkg::*;
#(
    parameter int WIDTH  = FRAME_W,
    parameter int HEIGHT = FRAME_H,
    parameter int DATA_W = 30,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sink_data,
    input  logic              sink_valid,
    input  logic              sink_startofpacket,
    input  logic              sink_endofpacket,
    output logic              sink_ready,
    input  logic              freeze,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              wr_en,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_count,
    output logic              busy
);

    localparam int                PIXELS    = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    wr_state_t         state, state_next;
    logic [ADDR_W-1:0] counter, counter_next;
    logic              freeze_latched, freeze_latched_next;

    logic              accept, beat_sop, beat_eop;
    logic              writing, at_last, good_end, frame_ends;
    logic [ADDR_W-1:0] beat_addr;

    logic              wr_en_next, frame_done_next, frame_err_next;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [PIX_W-1:0]  wr_data_next;
    logic [7:0]        frame_count_next;

    // A sop always restarts an open frame; outside a frame it only starts one when not frozen.
    assign accept     = sink_valid && sink_ready;
    assign beat_sop   = accept && sink_startofpacket;
    assign beat_eop   = accept && sink_endofpacket;
    assign writing    = (beat_sop && (state == WRITE || !freeze_latched)) || (accept && state == WRITE);
    assign beat_addr  = beat_sop ? '0 : counter;
    assign at_last    = (beat_addr == LAST_ADDR);
    assign good_end   = writing && beat_eop && at_last;
    assign frame_ends = writing ? (beat_eop || at_last) : (state == DROP && beat_eop && !beat_sop);
    assign busy       = (state == WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            freeze_latched <= 1'b0;
        end else begin
            state          <= state_next;
            counter        <= counter_next;
            freeze_latched <= freeze_latched_next;
        end
    end

    always_comb begin
        state_next          = state;
        counter_next        = counter;
        freeze_latched_next = freeze_latched;
        if (writing) begin
            if (beat_eop)
                state_next = IDLE;
            else if (at_last)
                state_next = DROP;
            else
                state_next = WRITE;
            counter_next = frame_ends ? '0 : beat_addr + ADDR_W'(1);
        end else if (state == DROP && (beat_sop || beat_eop)) begin
            state_next = IDLE;
        end
        // freeze only takes effect between frames so a frame in flight always completes.
        if (state == IDLE || frame_ends)
            freeze_latched_next = freeze;
    end

    always_comb begin
        wr_en_next       = writing;
        wr_addr_next     = writing ? beat_addr : wr_addr;
        wr_data_next     = writing ? PIX_W'(pack_rgb12(rgb30_t'(sink_data))) : wr_data;
        frame_done_next  = good_end;
        frame_err_next   = !good_end && ((state == WRITE && beat_sop) || (writing && (beat_eop || at_last)));
        frame_count_next = frame_count + 8'(good_end);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sink_ready  <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            sink_ready  <= 1'b1;
            wr_en       <= wr_en_next;
            wr_addr     <= wr_addr_next;
            wr_data     <= wr_data_next;
            frame_done  <= frame_done_next;
            frame_err   <= frame_err_next;
            frame_count <= frame_count_next;
        end
    end

endmodule

// File: tb/tb_st_frame_writer.sv
// Bench for st_frame_writer on a 4x2 frame: directed framing cases plus random frames,
// every cycle compared against a beat-level reference model of the framing rules.
module tb_st_frame_writer;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int PIX = W * H;
    localparam int AW  = 17;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] sink_data;
    logic        sink_valid;
    logic        sop;
    logic        eop;
    logic        sink_ready;
    logic        freeze;
    logic [AW-1:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_en;
    logic        frame_done;
    logic        frame_err;
    logic [7:0]  frame_count;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = between frames, 1 = inside a frame, 2 = discarding an overlong frame.
    int  m_mode, m_pos, m_count;
    bit  m_frz, m_ready;
    bit  e_en, e_done, e_err;
    int  e_addr, e_data;
    int  writes_seen;
    bit  use_fixed;
    logic [29:0] fixed_px;

    st_frame_writer #(
        .WIDTH (W),
        .HEIGHT(H),
        .DATA_W(30),
        .ADDR_W(AW),
        .PIX_W (12)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .sink_data         (sink_data),
        .sink_valid        (sink_valid),
        .sink_startofpacket(sop),
        .sink_endofpacket  (eop),
        .sink_ready        (sink_ready),
        .freeze            (freeze),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .wr_en             (wr_en),
        .frame_done        (frame_done),
        .frame_err         (frame_err),
        .frame_count       (frame_count),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    function automatic int pack12(input logic [29:0] d);
        int v;
        v = int'(d);
        return (((v >> 26) & 15) << 8) | (((v >> 16) & 15) << 4) | ((v >> 6) & 15);
    endfunction

    task automatic modelStep(input bit rst, input bit v, input bit s, input bit e,
                             input logic [29:0] d, input bit frz_in);
        bit acc, idle_now, ends;
        int w;
        e_en   = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (rst) begin
            m_mode  = 0;
            m_pos   = 0;
            m_frz   = 1'b0;
            m_ready = 1'b0;
            m_count = 0;
            e_addr  = 0;
            e_data  = 0;
        end else begin
            acc      = v && m_ready;
            m_ready  = 1'b1;
            idle_now = (m_mode == 0);
            ends     = 1'b0;
            w        = -1;
            if (acc) begin
                if (s) begin
                    if (m_mode == 1) begin
                        e_err = 1'b1;
                        w     = 0;
                    end else if (!m_frz) begin
                        w = 0;
                    end else begin
                        m_mode = 0;
                    end
                end else if (m_mode == 1) begin
                    w = m_pos;
                end else if (m_mode == 2 && e) begin
                    m_mode = 0;
                    ends   = 1'b1;
                end
                if (w >= 0) begin
                    e_en   = 1'b1;
                    e_addr = w;
                    e_data = pack12(d);
                    if (e) begin
                        m_mode = 0;
                        ends   = 1'b1;
                        if (w == PIX - 1) begin
                            e_done  = 1'b1;
                            e_err   = 1'b0;
                            m_count = (m_count + 1) % 256;
                        end else begin
                            e_err = 1'b1;
                        end
                    end else if (w == PIX - 1) begin
                        e_err  = 1'b1;
                        m_mode = 2;
                        ends   = 1'b1;
                    end else begin
                        m_mode = 1;
                        m_pos  = w + 1;
                    end
                end
            end
            if (idle_now || ends)
                m_frz = frz_in;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model on the same edge, then compare just after the edge.
    task automatic applyStimulus(input bit rst, input bit v, input bit s, input bit e, input logic [29:0] d);
        reset      = rst;
        sink_valid = v;
        sop        = s;
        eop        = e;
        sink_data  = d;
        @(posedge clk);
        modelStep(rst, v, s, e, d, freeze);
        #1;
        if (wr_en === 1'b1)
            writes_seen++;
        checkOutput("sink_ready",  32'(sink_ready),  32'(m_ready));
        checkOutput("wr_en",       32'(wr_en),       32'(e_en));
        checkOutput("wr_addr",     32'(wr_addr),     e_addr);
        checkOutput("wr_data",     32'(wr_data),     e_data);
        checkOutput("frame_done",  32'(frame_done),  32'(e_done));
        checkOutput("frame_err",   32'(frame_err),   32'(e_err));
        checkOutput("frame_count", 32'(frame_count), m_count);
        checkOutput("busy",        32'(busy),        32'(m_mode == 1));
        checkOutput("done_err_excl", 32'(frame_done & frame_err), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 30'($urandom));
    endtask

    // gaps: 0 = back-to-back, 1 = two idle cycles after each beat, 2 = random 0..2 idle cycles.
    task automatic sendFrame(input int len, input int eop_at, input int gaps, input int frz_at);
        logic [29:0] d;
        for (int i = 0; i < len; i++) begin
            if (i == frz_at)
                freeze = 1'b1;
            d = use_fixed ? fixed_px : 30'($urandom);
            applyStimulus(1'b0, 1'b1, i == 0, i == eop_at, d);
            if (gaps == 1)
                idle(2);
            else if (gaps == 2)
                idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        freeze      = 1'b0;
        use_fixed   = 1'b0;
        fixed_px    = {10'h3FF, 10'h000, 10'h155};
        reset       = 1'b1;
        sink_valid  = 1'b0;
        sop         = 1'b0;
        eop         = 1'b0;
        sink_data   = '0;
        writes_seen = 0;
        m_mode = 0; m_pos = 0; m_count = 0; m_frz = 1'b0; m_ready = 1'b0;
        e_addr = 0; e_data = 0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 30'($urandom));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 30'd0);
        checkOutput("reset_ready", 32'(sink_ready), 32'd0);
        idle(2);

        $display("[TB] good frame with fixed pixel");
        use_fixed = 1'b1;
        sendFrame(8, 7, 0, -1);
        use_fixed = 1'b0;
        checkOutput("good_done", 32'(frame_done), 32'd1);
        checkOutput("good_addr", 32'(wr_addr), 32'd7);
        checkOutput("good_data", 32'(wr_data), 32'h0F05);
        checkOutput("good_count", 32'(frame_count), 32'd1);
        idle(2);

        $display("[TB] short frame");
        writes_seen = 0;
        sendFrame(6, 5, 0, -1);
        checkOutput("short_err", 32'(frame_err), 32'd1);
        checkOutput("short_writes", writes_seen, 32'd6);
        checkOutput("short_count", 32'(frame_count), 32'd1);
        idle(1);

        $display("[TB] long frame then sop while dropping");
        sendFrame(10, -1, 0, -1);
        checkOutput("long_busy", 32'(busy), 32'd0);
        sendFrame(8, 7, 0, -1);
        checkOutput("restart_count", 32'(frame_count), 32'd2);
        idle(1);

        $display("[TB] valid gaps");
        writes_seen = 0;
        sendFrame(8, 7, 1, -1);
        checkOutput("gaps_writes", writes_seen, 32'd8);
        checkOutput("gaps_count", 32'(frame_count), 32'd3);

        $display("[TB] freeze");
        sendFrame(8, 7, 0, 3);
        checkOutput("freeze_f1_count", 32'(frame_count), 32'd4);
        idle(2);
        writes_seen = 0;
        sendFrame(8, 7, 0, -1);
        checkOutput("freeze_f2_writes", writes_seen, 32'd0);
        checkOutput("freeze_f2_ready", 32'(sink_ready), 32'd1);
        checkOutput("freeze_f2_count", 32'(frame_count), 32'd4);
        freeze = 1'b0;
        idle(2);
        writes_seen = 0;
        sendFrame(8, 7, 0, -1);
        checkOutput("freeze_f3_writes", writes_seen, 32'd8);
        checkOutput("freeze_f3_count", 32'(frame_count), 32'd5);
        idle(1);

        $display("[TB] reset mid-frame");
        sendFrame(4, -1, 0, -1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 30'($urandom));
        checkOutput("midrst_ready", 32'(sink_ready), 32'd0);
        checkOutput("midrst_err", 32'(frame_err), 32'd0);
        checkOutput("midrst_count", 32'(frame_count), 32'd0);
        idle(1);
        sendFrame(8, 7, 0, -1);
        checkOutput("after_rst_count", 32'(frame_count), 32'd1);

        $display("[TB] sop inside a frame");
        sendFrame(3, -1, 0, -1);
        sendFrame(8, 7, 0, -1);
        checkOutput("restart_write_count", 32'(frame_count), 32'd2);

        $display("[TB] random frames");
        for (int f = 0; f < 16; f++) begin
            int len, eop_at;
            freeze = ($urandom_range(0, 3) == 0);
            len    = int'($urandom_range(5, 11));
            eop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : PIX - 1;
            sendFrame(len, eop_at, 2, -1);
            idle(int'($urandom_range(0, 3)));
        end
        freeze = 1'b0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
